// File: rtl/addsub_result_stage.sv
// Result stage behind the adder/subtractor: range check, status flags, 2-entry
// output FIFO and a saturating overflow-event counter. Define ADDSUB_RESULT_SAT_EN to clamp out-of-range results instead of wrapping them.
//
// state | meaning
// EMPTY | no entries held, out_valid low
// ONE   | one entry held, can accept and present
// FULL  | two entries held, in_ready low
module addsub_result_stage #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N+1:0]     in_sum,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     out_result,
    output logic             out_sel,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int EW = N + 3;
    localparam logic signed [N+1:0] SUM_MAX = {3'b000, {(N-1){1'b1}}};
    localparam logic signed [N+1:0] SUM_MIN = {3'b111, {(N-1){1'b0}}};
`ifdef ADDSUB_RESULT_SAT_EN
    localparam logic [N-1:0] RES_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] RES_MIN = {1'b1, {(N-1){1'b0}}};
`endif

    state_t          state;
    logic            wr_ptr;
    logic            rd_ptr;
    logic [EW-1:0]   mem [2];
    logic            push;
    logic            pop;
    logic            sum_hi;
    logic            sum_lo;
    logic            push_ovf;
    logic [N-1:0]    push_res;
    logic [EW-1:0]   push_entry;

    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign sum_hi   = $signed(in_sum) > SUM_MAX;
    assign sum_lo   = $signed(in_sum) < SUM_MIN;
    assign push_ovf = sum_hi || sum_lo;

    always_comb begin
        push_res = in_sum[N-1:0];
`ifdef ADDSUB_RESULT_SAT_EN
        if (sum_hi) begin
            push_res = RES_MAX;
        end else if (sum_lo) begin
            push_res = RES_MIN;
        end
`endif
    end

    // Zero is stored per entry so that the reset view of out_zero is 0.
    assign push_entry = {in_sel, push_ovf, (push_res == '0), push_res};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state    <= FULL;
                        in_ready <= 1'b0;
                    end else if (!push && pop) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    assign {out_sel, out_ovf, out_zero, out_result} = mem[rd_ptr];
    assign out_neg = out_result[N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (ovf_clr) begin
            ovf_count <= '0;
        end else if (push && push_ovf && (ovf_count != {CNT_W{1'b1}})) begin
            ovf_count <= ovf_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_addsub_result_stage.sv
// Bench for addsub_result_stage: queue model of the stage plus directed vectors.
module tb_addsub_result_stage;
    localparam int N     = 4;
    localparam int CNT_W = 2;
    localparam int RMAX  = (1 << (N-1)) - 1;
    localparam int RMIN  = -(1 << (N-1));
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                   clk;
    logic                   rst_n;
    logic signed [N+1:0]    in_sum;
    logic                   in_sel;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [N-1:0]    out_result;
    logic                   out_sel;
    logic                   out_zero;
    logic                   out_neg;
    logic                   out_ovf;
    logic                   out_valid;
    logic                   out_ready;
    logic [CNT_W-1:0]       ovf_count;
    logic                   ovf_clr;

    addsub_result_stage #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_sum(in_sum), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_result(out_result),
        .out_sel(out_sel), .out_zero(out_zero), .out_neg(out_neg),
        .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready),
        .ovf_count(ovf_count), .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int res;
        bit sel;
        bit ovf;
    } ent_t;

    ent_t q[$];
    int   cnt_m;
    int   pass_cnt;
    int   total_cnt;
    int   rec[$];
    bit   rec_en;
    int   ready_drops;
    bit   watch_ready;

    task automatic check(string name, int act, int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t model(int s, bit sel);
        ent_t e;
        e.sel = sel;
        e.ovf = (s > RMAX) || (s < RMIN);
`ifdef ADDSUB_RESULT_SAT_EN
        e.res = (s > RMAX) ? RMAX : (s < RMIN) ? RMIN : s;
`else
        e.res = s & ((1 << N) - 1);
        if (e.res > RMAX) e.res -= (1 << N);
`endif
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cnt_m = 0;
        end else begin
            bit   do_pop;
            bit   do_push;
            ent_t e;
            do_pop  = out_ready && (q.size() > 0);
            do_push = in_valid && (q.size() < 2);
            e = model(int'(in_sum), in_sel);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(e);
            if (ovf_clr) cnt_m = 0;
            else if (do_push && e.ovf && cnt_m < CMAX) cnt_m++;
            if (watch_ready && !in_ready) ready_drops++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", int'(in_ready), int'(q.size() < 2));
            check("out_valid", int'(out_valid), int'(q.size() > 0));
            check("ovf_count", int'(ovf_count), cnt_m);
            if (q.size() > 0) begin
                check("out_result", int'(out_result), q[0].res);
                check("out_sel", int'(out_sel), int'(q[0].sel));
                check("out_ovf", int'(out_ovf), int'(q[0].ovf));
                check("out_zero", int'(out_zero), int'(q[0].res == 0));
                check("out_neg", int'(out_neg), int'(q[0].res < 0));
            end
            if (rec_en && out_valid && out_ready) rec.push_back(int'(out_result));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(int v, bit sel);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_sum   = (N+2)'(v);
        in_sel   = sel;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("push_timeout", 0, 1);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0; ready_drops = 0;
        rec_en = 0; watch_ready = 0;
        rst_n = 0; in_sum = '0; in_sel = 0; in_valid = 0; out_ready = 0; ovf_clr = 0;
        #11;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_result", int'(out_result), 0);
        check("rst_out_zero", int'(out_zero), 0);
        rst_n = 1;
        idle(2);

        out_ready = 1;
        push(5, 0);
        at_neg();
        check("p5_result", int'(out_result), 5);
        check("p5_zero", int'(out_zero), 0);
        check("p5_neg", int'(out_neg), 0);
        check("p5_ovf", int'(out_ovf), 0);
        idle(1);
        push(-8, 1);
        at_neg();
        check("m8_result", int'(out_result), -8);
        check("m8_neg", int'(out_neg), 1);
        check("m8_ovf", int'(out_ovf), 0);
        check("m8_sel", int'(out_sel), 1);
        idle(1);
        push(0, 0);
        at_neg();
        check("z_zero", int'(out_zero), 1);
        idle(1);
        push(9, 0);
        at_neg();
        check("p9_ovf", int'(out_ovf), 1);
        check("p9_count", int'(ovf_count), 1);
`ifdef ADDSUB_RESULT_SAT_EN
        check("p9_result", int'(out_result), 7);
        check("p9_neg", int'(out_neg), 0);
`else
        check("p9_result", int'(out_result), -7);
        check("p9_neg", int'(out_neg), 1);
`endif
        idle(1);
        push(-10, 1);
        at_neg();
        check("m10_ovf", int'(out_ovf), 1);
        check("m10_count", int'(ovf_count), 2);
`ifdef ADDSUB_RESULT_SAT_EN
        check("m10_result", int'(out_result), -8);
`else
        check("m10_result", int'(out_result), 6);
`endif
        idle(2);

        // backpressure
        out_ready = 0;
        push(1, 0);
        push(2, 0);
        check("bp_full_ready", int'(in_ready), 0);
        in_valid = 1; in_sum = (N+2)'(3); in_sel = 0;
        idle(3);
        check("bp_held_ready", int'(in_ready), 0);
        check("bp_head", int'(out_result), 1);
        rec.delete();
        rec_en = 1;
        out_ready = 1;
        push(3, 0);
        idle(4);
        rec_en = 0;
        check("bp_count", rec.size(), 3);
        for (int i = 0; i < rec.size() && i < 3; i++) check("bp_order", rec[i], i + 1);

        // streaming at occupancy 1
        rec.delete();
        rec_en = 1;
        watch_ready = 1;
        for (int v = 1; v <= 20; v++) begin
            in_valid = 1; in_sum = (N+2)'(v); in_sel = v[0];
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        watch_ready = 0;
        idle(3);
        rec_en = 0;
        check("stream_count", rec.size(), 20);
        check("stream_ready_drops", ready_drops, 0);
        for (int i = 0; i < rec.size() && i < 20; i++) check("stream_order", rec[i], model(i + 1, 0).res);
        if (rec.size() == 20) begin
            check("stream_first", rec[0], 1);
`ifdef ADDSUB_RESULT_SAT_EN
            check("stream_last", rec[19], 7);
`else
            check("stream_last", rec[19], 4);
`endif
        end

        // counter saturation and clear priority
        ovf_clr = 1;
        idle(1);
        ovf_clr = 0;
        check("clr_count", int'(ovf_count), 0);
        for (int i = 0; i < 5; i++) push(9, 0);
        check("sat_count", int'(ovf_count), 3);
        ovf_clr = 1;
        push(9, 0);
        ovf_clr = 0;
        check("clr_prio_count", int'(ovf_count), 0);
        idle(2);

        // reset mid-stream
        out_ready = 0;
        push(9, 0);
        push(-10, 0);
        check("pre_rst_ready", int'(in_ready), 0);
        check("pre_rst_count", int'(ovf_count), 2);
        at_neg();
        rst_n = 0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_count", int'(ovf_count), 0);
        check("mid_rst_result", int'(out_result), 0);
        idle(1);
        rst_n = 1;
        idle(1);
        out_ready = 1;
        push(5, 0);
        at_neg();
        check("post_rst_result", int'(out_result), 5);
        idle(3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
